// File: rtl/alu_exec.sv
// Execute-stage ALU: 1-cycle add/sub/and/or/slt, iterative unsigned multiply,
// valid/ready on both sides with a single registered output slot.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic               r_zero;
  logic               r_illegal;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_last;
  logic [WIDTH-1:0]   w_res;
  logic               w_ill;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign in_ready  = (r_state == S_IDLE) &&
                     (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = (alucontrol == 3'b011);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign hi        = r_hi;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    unique case (alucontrol)
      3'b010: w_res = srca + srcb;
      3'b110: w_res = srca - srcb;
      3'b000: w_res = srca & srcb;
      3'b001: w_res = srca | srcb;
      3'b111: w_res = {{(WIDTH-1){1'b0}},
                       ($signed(srca) < $signed(srcb))};
      3'b011: w_res = '0;
      3'b100: w_ill = 1'b1;
      3'b101: w_ill = 1'b1;
      default: w_res = '0;
    endcase
  end

  // Shift-add step: carry out of the upper-half add shifts into the MSB
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_hi        <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_acc   <= {{WIDTH{1'b0}}, srcb};
              r_mcand <= srca;
              r_cnt   <= '0;
              r_state <= S_MUL;
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_hi        <= '0;
              r_zero      <= (w_res == '0);
              r_illegal   <= w_ill;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_nxt[WIDTH-1:0];
            r_hi        <= w_acc_nxt[2*WIDTH-1:WIDTH];
            r_zero      <= (w_acc_nxt[WIDTH-1:0] == '0);
            r_illegal   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected results queued at accept,
// compared when the output slot is presented.
module tb_alu_exec;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        illegal;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  alu_exec #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .hi         (hi),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [2:0] op,
                                 logic [31:0] a,
                                 logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e = '0;
    case (op)
      3'b010: e.res = a + b;
      3'b110: e.res = a - b;
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b111: e.res = {31'b0, $signed(a) < $signed(b)};
      3'b011: begin
        p = 64'(a) * 64'(b);
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accept edge
  task automatic issue(logic [2:0] op, logic [31:0] a,
                       logic [31:0] b);
    bit ok;
    ok = 0;
    in_valid   = 1'b1;
    alucontrol = op;
    srca       = a;
    srcb       = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        q.push_back(model(op, a, b));
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    srca       = $urandom;
    srcb       = $urandom;
    alucontrol = 3'($urandom);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        chk("result",  64'(result),  64'(q[0].res));
        chk("hi",      64'(hi),      64'(q[0].hi));
        chk("zero",    64'(zero),    64'(q[0].zero));
        chk("illegal", 64'(illegal), 64'(q[0].ill));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    alucontrol = 3'b000;
    srca       = '0;
    srcb       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_hi",        64'(hi),        64'd0);
    chk("rst_zero",      64'(zero),      64'd0);
    chk("rst_illegal",   64'(illegal),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1 reset = 1'b1;

    // add latency 1
    issue(3'b010, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_lat", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    issue(3'b110, 32'd3, 32'd3);
    issue(3'b111, 32'hFFFF_FFFF, 32'd1);

    // multu: busy for 32 cycles
    issue(3'b011, 32'hFFFF_FFFF, 32'd2);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      chk("mul_busy", {62'd0, in_ready, out_valid}, 64'd0);
    end
    @(negedge clk);
    chk("mul_lat", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // backpressure
    out_ready = 1'b0;
    issue(3'b010, 32'd1, 32'd1);
    fork
      issue(3'b000, 32'hF0, 32'h3C);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_hold",     64'(result),   64'd2);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    @(negedge clk);
    chk("bp_and_lat", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // reset during multiply
    issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    chk("abort_result",    64'(result),    64'd0);
    chk("abort_hi",        64'(hi),        64'd0);
    @(posedge clk);
    #1;
    issue(3'b010, 32'd1, 32'd2);

    // illegal code, then a legal op clears the flag
    issue(3'b100, 32'd9, 32'd4);
    @(negedge clk);
    chk("ill_lat", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    issue(3'b001, 32'h0F, 32'hF0);
    issue(3'b101, 32'd0, 32'd0);

    // random mix, including multiplies and signed compares
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      issue(op, a, b);
    end

    for (int i = 0; i < 100 && q.size() > 0; i++)
      @(posedge clk);
    chk("drain", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
